// File: rtl/game_control.sv
// Genius memory game sequencer: steps the datapath through setup,
// playback, user entry, checking, round advance and result display.
module game_control #(
  parameter int P_CLR_CYC = 2,
  parameter int P_STATE   = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enter_i,
  input  logic               end_fpga_i,
  input  logic               end_user_i,
  input  logic               end_time_i,
  input  logic               win_i,
  input  logic               match_i,
  output logic               r1_o,
  output logic               r2_o,
  output logic               e1_o,
  output logic               e2_o,
  output logic               e3_o,
  output logic               e4_o,
  output logic               sel_o,
  output logic               result_o,
  output logic [P_STATE-1:0] state_o
);

  localparam int CW =
    (P_CLR_CYC > 1) ? $clog2(P_CLR_CYC) : 1;
  localparam logic [CW-1:0] CLR_LAST =
    CW'(P_CLR_CYC - 1);

  typedef enum logic [P_STATE-1:0] {
    S_INIT   = P_STATE'(0),
    S_SETUP  = P_STATE'(1),
    S_CLEAR  = P_STATE'(2),
    S_SEQ    = P_STATE'(3),
    S_PLAY   = P_STATE'(4),
    S_CHECK  = P_STATE'(5),
    S_NEXT   = P_STATE'(6),
    S_RESULT = P_STATE'(7)
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          res_q, res_d;
  logic          enter_q;
  logic          pulse_q;

  // enter_q resets high so a press held across reset release is ignored
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      res_q   <= 1'b0;
      enter_q <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      enter_q <= enter_i;
      pulse_q <= enter_i & ~enter_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    res_d   = res_q;
    case (state_q)
      S_INIT: begin
        state_d = S_SETUP;
        res_d   = 1'b0;
      end
      S_SETUP: begin
        if (pulse_q) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (cnt_q == CLR_LAST) state_d = S_SEQ;
        else cnt_d = cnt_q + CW'(1);
      end
      S_SEQ: begin
        if (end_fpga_i) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (end_user_i) begin
          state_d = S_CHECK;
        end else if (end_time_i) begin
          state_d = S_RESULT;
          res_d   = 1'b0;
        end
      end
      S_CHECK: begin
        if (!match_i) begin
          state_d = S_RESULT;
          res_d   = 1'b0;
        end else if (win_i) begin
          state_d = S_RESULT;
          res_d   = 1'b1;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        state_d = S_CLEAR;
      end
      S_RESULT: begin
        if (pulse_q) begin
          state_d = S_INIT;
          res_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_INIT;
        res_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    r1_o  = 1'b0;
    r2_o  = 1'b0;
    e1_o  = 1'b0;
    e2_o  = 1'b0;
    e3_o  = 1'b0;
    e4_o  = 1'b0;
    sel_o = 1'b0;
    case (state_q)
      S_INIT: begin
        r1_o  = 1'b1;
        r2_o  = 1'b1;
        sel_o = 1'b1;
      end
      S_SETUP: begin
        e1_o  = 1'b1;
        sel_o = 1'b1;
      end
      S_CLEAR: begin
        r2_o  = 1'b1;
        sel_o = 1'b1;
      end
      S_SEQ: begin
        e3_o  = 1'b1;
        sel_o = 1'b1;
      end
      S_PLAY: begin
        e2_o  = 1'b1;
        sel_o = 1'b1;
      end
      S_CHECK: sel_o = 1'b1;
      S_NEXT:  e4_o  = 1'b1;
      default: ;
    endcase
  end

  assign result_o = res_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_game_control.sv
// Scoreboard bench for game_control: a rule-level game model predicts
// every cycle's outputs; a negedge monitor compares them with the DUT.
module tb_game_control;

  localparam int CLR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enter = 1'b0;
  logic fpga = 1'b0;
  logic user = 1'b0;
  logic tmo = 1'b0;
  logic win = 1'b0;
  logic match = 1'b0;
  logic r1, r2, e1, e2, e3, e4, sel, res;
  logic [2:0] st;

  int n_cmp = 0;
  int n_bad = 0;

  game_control #(.P_CLR_CYC(CLR), .P_STATE(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enter_i(enter),
    .end_fpga_i(fpga), .end_user_i(user),
    .end_time_i(tmo), .win_i(win), .match_i(match),
    .r1_o(r1), .r2_o(r2), .e1_o(e1), .e2_o(e2),
    .e3_o(e3), .e4_o(e4), .sel_o(sel),
    .result_o(res), .state_o(st)
  );

  always #10 clk = ~clk;

  // game phases, numbered as the debug LEDs show them
  localparam int INIT = 0, SETUP = 1, CLEAR = 2, SEQ = 3;
  localparam int PLAY = 4, CHECK = 5, NEXT = 6, RESULT = 7;

  function automatic logic [10:0] expect_out(int s, bit r);
    logic [7:0] f;
    f[7] = (s == INIT);
    f[6] = (s == INIT) || (s == CLEAR);
    f[5] = (s == SETUP);
    f[4] = (s == PLAY);
    f[3] = (s == SEQ);
    f[2] = (s == NEXT);
    f[1] = (s <= CHECK);
    f[0] = r;
    return {f, 3'(s)};
  endfunction

  function automatic logic [10:0] dut_out();
    return {r1, r2, e1, e2, e3, e4, sel, res, st};
  endfunction

  task automatic check(string nm, logic [10:0] act,
                       logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (r1 r2 e1 e2 e3 e4 sel res state)",
               nm, act, exp);
    end
  endtask

  // reference game model
  int  m_s;
  bit  m_res;
  int  m_left;
  bit  m_prev;
  bit  m_press;
  logic [10:0] sb[$];

  task automatic model_reset();
    m_s = INIT;
    m_res = 1'b0;
    m_left = 0;
    m_prev = 1'b1;
    m_press = 1'b0;
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      int nx;
      nx = m_s;
      case (m_s)
        INIT: begin nx = SETUP; m_res = 1'b0; end
        SETUP: if (m_press) begin nx = CLEAR; m_left = CLR; end
        CLEAR: begin
          m_left = m_left - 1;
          if (m_left == 0) nx = SEQ;
        end
        SEQ: if (fpga) nx = PLAY;
        PLAY:
          if (user) nx = CHECK;
          else if (tmo) begin nx = RESULT; m_res = 1'b0; end
        CHECK: begin
          nx = match ? (win ? RESULT : NEXT) : RESULT;
          m_res = match && win;
        end
        NEXT: begin nx = CLEAR; m_left = CLR; end
        RESULT: if (m_press) begin nx = INIT; m_res = 1'b0; end
        default: nx = INIT;
      endcase
      m_s = nx;
      m_press = enter && !m_prev;
      m_prev = enter;
    end
    sb.push_back(expect_out(m_s, m_res));
  end

  always @(negedge clk) begin
    if (sb.size() > 0) check("cycle", dut_out(), sb.pop_front());
  end

  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_in(bit en, bit f, bit u, bit t,
                        bit w, bit m);
    enter = en; fpga = f; user = u;
    tmo = t; win = w; match = m;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_out(), 11'b11000010_000);
    step(1);
    rst_n = 1'b1;
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    step(2);
    set_in(1, 0, 0, 0, 0, 0);
    step(10);
    set_in(0, 0, 0, 0, 0, 0);
    step(2);
    // normal round
    set_in(0, 1, 0, 0, 0, 1);
    step(1);
    set_in(0, 0, 1, 0, 0, 1);
    step(1);
    set_in(0, 0, 0, 0, 0, 1);
    step(5);
    // final-round win
    set_in(0, 1, 0, 0, 1, 1);
    step(1);
    set_in(0, 0, 1, 0, 1, 1);
    step(1);
    set_in(0, 0, 0, 0, 1, 1);
    step(3);
    set_in(1, 0, 0, 0, 0, 0);
    step(4);
    set_in(0, 0, 0, 0, 0, 0);
    step(1);
    set_in(1, 0, 0, 0, 0, 0);
    step(4);
    // wrong sequence
    set_in(0, 1, 0, 0, 0, 0);
    step(1);
    set_in(0, 0, 1, 0, 0, 0);
    step(1);
    set_in(0, 0, 0, 0, 0, 0);
    step(3);
    set_in(1, 0, 0, 0, 0, 0);
    step(4);
    set_in(0, 0, 0, 0, 0, 0);
    step(1);
    set_in(1, 0, 0, 0, 0, 0);
    step(4);
    // timeout, then simultaneous user/timeout
    set_in(0, 1, 0, 0, 0, 1);
    step(1);
    set_in(0, 0, 0, 1, 0, 1);
    step(2);
    set_in(1, 0, 0, 0, 0, 1);
    step(4);
    set_in(0, 0, 0, 0, 0, 1);
    step(1);
    set_in(1, 0, 0, 0, 0, 1);
    step(4);
    set_in(0, 1, 0, 0, 0, 1);
    step(1);
    set_in(0, 0, 1, 1, 0, 1);
    step(1);
    set_in(0, 0, 0, 0, 0, 1);
    step(4);
    // mid-game reset while in PLAY
    set_in(0, 1, 0, 0, 0, 1);
    step(1);
    set_in(0, 0, 0, 0, 0, 1);
    step(1);
    do_reset();
    step(3);
    // randomized play
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      set_in($urandom_range(0, 5) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 4) == 0,
             $urandom_range(0, 9) == 0,
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) != 0);
      step(1);
    end
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
